// File: rtl/sync_fifo_pt.sv
// Show-ahead valid/ready FIFO with occupancy, level flags, flush and high-water mark; a written word is visible after one edge.
// Backpressure: o_ready_s drops when full (optionally held high by a same-cycle read); a stalled master just holds its word.
module sync_fifo_pt #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1,
    parameter bit FULL_PASS  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_valid_s,
    output logic                  o_ready_s,
    input  logic [DATA_WIDTH-1:0] i_datain,
    output logic                  o_valid_m,
    input  logic                  i_ready_m,
    output logic [DATA_WIDTH-1:0] o_dataout,
    input  logic [LVL_WIDTH-1:0]  i_almostfull_lvl,
    input  logic [LVL_WIDTH-1:0]  i_almostempty_lvl,
    input  logic                  i_clr_stat,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almostfull,
    output logic                  o_almostempty,
    output logic [LVL_WIDTH-1:0]  o_count,
    output logic [LVL_WIDTH-1:0]  o_max_count
);

    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [LVL_WIDTH-1:0]  r_count;
    logic [LVL_WIDTH-1:0]  r_max_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic [LVL_WIDTH-1:0]  w_count_next;
    logic [LVL_WIDTH-1:0]  w_max_next;

    // Pointer MSB is the wrap bit: equal addresses with differing laps means full.
    assign w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                     (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_valid_m = ~w_empty;
    assign o_ready_s = FULL_PASS ? (~w_full | i_ready_m) : ~w_full;

    assign w_wr_fire = i_valid_s & o_ready_s;
    assign w_rd_fire = o_valid_m & i_ready_m;

    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + LVL_WIDTH'(w_wr_fire) - LVL_WIDTH'(w_rd_fire);
        end
    end

    always_comb begin
        w_max_next = r_max_count;
        if (i_clr_stat) begin
            w_max_next = w_count_next;
        end else if (w_count_next > r_max_count) begin
            w_max_next = w_count_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_max_count <= '0;
        end else begin
            r_count     <= w_count_next;
            r_max_count <= w_max_next;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_fire) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_rd_fire) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    // In full pass-through the write lands in the slot being read this cycle; the read sees the old word.
    always_ff @(posedge i_clk) begin
        if (w_wr_fire && !i_flush && !i_rst) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= i_datain;
        end
    end

    assign o_dataout     = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign o_count       = r_count;
    assign o_max_count   = r_max_count;
    assign o_almostfull  = (r_count >= i_almostfull_lvl);
    assign o_almostempty = (r_count <= i_almostempty_lvl);

endmodule

// File: tb/tb_sync_fifo_pt.sv
// Bench for sync_fifo_pt: threshold vector table, hand-written corner sequences, and random traffic vs a queue model.
module tb_sync_fifo_pt;

    localparam int DEPTH     = 16;
    localparam int DW        = 32;
    localparam int LW        = 5;
    localparam bit FULL_PASS = 1'b1;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_flush;
    logic          i_valid_s;
    logic          o_ready_s;
    logic [DW-1:0] i_datain;
    logic          o_valid_m;
    logic          i_ready_m;
    logic [DW-1:0] o_dataout;
    logic [LW-1:0] i_almostfull_lvl;
    logic [LW-1:0] i_almostempty_lvl;
    logic          i_clr_stat;
    logic          o_full;
    logic          o_empty;
    logic          o_almostfull;
    logic          o_almostempty;
    logic [LW-1:0] o_count;
    logic [LW-1:0] o_max_count;

    sync_fifo_pt #(
        .FIFO_DEPTH(DEPTH),
        .DATA_WIDTH(DW),
        .LVL_WIDTH (LW),
        .FULL_PASS (FULL_PASS)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_flush          (i_flush),
        .i_valid_s        (i_valid_s),
        .o_ready_s        (o_ready_s),
        .i_datain         (i_datain),
        .o_valid_m        (o_valid_m),
        .i_ready_m        (i_ready_m),
        .o_dataout        (o_dataout),
        .i_almostfull_lvl (i_almostfull_lvl),
        .i_almostempty_lvl(i_almostempty_lvl),
        .i_clr_stat       (i_clr_stat),
        .o_full           (o_full),
        .o_empty          (o_empty),
        .o_almostfull     (o_almostfull),
        .o_almostempty    (o_almostempty),
        .o_count          (o_count),
        .o_max_count      (o_max_count)
    );

    always #5 i_clk = ~i_clk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] mdl_q[$];
    int            mdl_max = 0;
    logic [DW-1:0] src_dat;

    typedef struct {
        logic          vs;
        logic          rm;
        logic [LW-1:0] exp_cnt;
        logic          exp_af;
        logic          exp_ae;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs follow from the queue occupancy alone.
    task automatic check_outputs();
        int cnt;
        cnt = mdl_q.size();
        chk("count", 64'(o_count), 64'(cnt));
        chk("empty", 64'(o_empty), 64'(cnt == 0));
        chk("full", 64'(o_full), 64'(cnt == DEPTH));
        chk("valid_m", 64'(o_valid_m), 64'(cnt != 0));
        chk("ready_s", 64'(o_ready_s), 64'((cnt < DEPTH) || (FULL_PASS && i_ready_m)));
        chk("almostfull", 64'(o_almostfull), 64'(cnt >= int'(i_almostfull_lvl)));
        chk("almostempty", 64'(o_almostempty), 64'(cnt <= int'(i_almostempty_lvl)));
        chk("max_count", 64'(o_max_count), 64'(mdl_max));
        if (cnt > 0) begin
            chk("dataout", 64'(o_dataout), 64'(mdl_q[0]));
        end
    endtask

    // Drive one cycle, check pre-edge outputs, advance the model, then step past the edge.
    task automatic cycle(input logic vs, input logic rm, input logic fl, input logic clr);
        bit rdy, wr, rd;
        i_valid_s  = vs;
        i_ready_m  = rm;
        i_flush    = fl;
        i_clr_stat = clr;
        i_datain   = src_dat;
        #1;
        check_outputs();
        rdy = (mdl_q.size() < DEPTH) || (FULL_PASS && rm);
        wr  = vs && rdy;
        rd  = (mdl_q.size() > 0) && rm;
        if (fl) begin
            mdl_q.delete();
        end else begin
            if (rd) void'(mdl_q.pop_front());
            if (wr) mdl_q.push_back(src_dat);
        end
        if (clr || mdl_q.size() > mdl_max) mdl_max = mdl_q.size();
        @(posedge i_clk);
        #2;
        if (wr) src_dat = $urandom;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 5'd1, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 5'd2, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 5'd3, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 5'd4, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 5'd5, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 5'd6, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 5'd5, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 5'd4, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 5'd3, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 5'd2, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 5'd1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 5'd0, 1'b0, 1'b1};

        src_dat           = $urandom;
        i_rst             = 1'b1;
        i_flush           = 1'b0;
        i_valid_s         = 1'b0;
        i_ready_m         = 1'b0;
        i_clr_stat        = 1'b0;
        i_datain          = '0;
        i_almostempty_lvl = 5'd2;
        i_almostfull_lvl  = 5'd5;

        // Reset values, including almost-full with a zero level.
        #3;
        check_outputs();
        i_almostfull_lvl = 5'd0;
        #1;
        chk("rst_af_lvl0", 64'(o_almostfull), 64'd1);
        i_almostfull_lvl = 5'd5;
        #9;
        i_rst = 1'b0;
        @(posedge i_clk);
        #2;

        // Thresholds AE=2, AF=5: write 6 then read 6.
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].vs, tbl[i].rm, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_count", i), 64'(o_count), 64'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_af", i), 64'(o_almostfull), 64'(tbl[i].exp_af));
            chk($sformatf("tbl%0d_ae", i), 64'(o_almostempty), 64'(tbl[i].exp_ae));
        end

        // Mid-cycle reset with writes in flight; the edge under reset must not accept anything.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        i_rst = 1'b1;
        #1;
        mdl_q.delete();
        mdl_max = 0;
        check_outputs();
        chk("rst_ready_s", 64'(o_ready_s), 64'd1);
        @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_count", 64'(o_count), 64'd0);

        // Overflow attempt then drain.
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("fill_full", 64'(o_full), 64'd1);
        chk("fill_count", 64'(o_count), 64'd16);
        chk("fill_max", 64'(o_max_count), 64'd16);
        chk("fill_ready_s", 64'(o_ready_s), 64'd0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("drain_empty", 64'(o_empty), 64'd1);
        chk("drain_valid_m", 64'(o_valid_m), 64'd0);

        // Full pass-through.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pass_count", 64'(o_count), FULL_PASS ? 64'd16 : 64'd6);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Flush and statistics.
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("flushclr_max", 64'(o_max_count), 64'd0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 64'(o_count), 64'd0);
        chk("flush_empty", 64'(o_empty), 64'd1);
        chk("flush_max", 64'(o_max_count), 64'd9);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_max", 64'(o_max_count), 64'd0);

        // Random traffic with phase-dependent bias and on-the-fly level changes.
        for (int i = 0; i < 3000; i++) begin
            int wr_pct, rd_pct;
            wr_pct = ((i / 200) % 3 == 0) ? 85 : (((i / 200) % 3 == 1) ? 30 : 60);
            rd_pct = ((i / 200) % 3 == 0) ? 30 : (((i / 200) % 3 == 1) ? 85 : 60);
            if ($urandom_range(0, 19) == 0) begin
                i_almostfull_lvl  = LW'($urandom_range(0, DEPTH + 2));
                i_almostempty_lvl = LW'($urandom_range(0, DEPTH + 2));
            end
            cycle($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < rd_pct,
                  $urandom_range(0, 149) == 0, $urandom_range(0, 99) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
